// File: rtl/multi_fifo_pkg.sv
// Shared definitions for the multi-reader FIFO read stage: lane state encoding
// and default parameter values.
package multi_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_READER_NUM = 2;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } lane_state_t;

endpackage

// File: rtl/multi_fifo_rd_stage_if.sv
// Bundle of per-lane FIFO-side and consumer-side signals of the read stage.
// The master modport is the read stage itself; slave is the surrounding logic.
interface multi_fifo_rd_stage_if
   import multi_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int READER_NUM = DEF_READER_NUM,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

   logic [READER_NUM-1:0]                 fifo_empty_i;
   logic [READER_NUM-1:0]                 fifo_rden_o;
   logic [READER_NUM-1:0][DATA_WIDTH-1:0] fifo_rdata_i;
   logic [READER_NUM-1:0]                 valid_o;
   logic [READER_NUM-1:0]                 ready_i;
   logic [READER_NUM-1:0][DATA_WIDTH-1:0] data_o;
   logic [READER_NUM-1:0][CNT_WIDTH-1:0]  beat_cnt_o;

   modport master (
      input  fifo_empty_i, fifo_rdata_i, ready_i,
      output fifo_rden_o, valid_o, data_o, beat_cnt_o
   );

   modport slave (
      output fifo_empty_i, fifo_rdata_i, ready_i,
      input  fifo_rden_o, valid_o, data_o, beat_cnt_o
   );

endinterface

// File: rtl/multi_fifo_rd_stage_rd_skid_buf.sv
// Single read lane: two-entry head/skid buffer between a fall-through FIFO
// and a valid/ready consumer, with a wrapping delivered-word counter.
module rd_skid_buf
   import multi_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  ready,
   output logic                  fifo_rden,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [CNT_WIDTH-1:0]  beat_cnt
);

   lane_state_t           state;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;
   logic                  push;
   logic                  pop;

   // Pop depends only on local state, never on ready, so the consumer cannot
   // form a combinational loop back into the FIFO.
   assign fifo_rden = !fifo_empty && (state != TWO) && !rst;
   assign push      = fifo_rden;
   assign valid     = (state != EMPTY);
   assign pop       = valid && ready;
   assign data      = head;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data registers are reset too so data_o reads zero during
         // reset; they are only two words per lane, not a memory array.
         state    <= EMPTY;
         head     <= '0;
         skid     <= '0;
         beat_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register in this
         // block samples the pre-edge values of the others.
         case (state)
            EMPTY: begin
               if (push) begin
                  head  <= fifo_rdata;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid  <= fifo_rdata;
                  state <= TWO;
               end else if (push && pop) begin
                  head <= fifo_rdata;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
         if (pop) beat_cnt <= beat_cnt + 1'b1;
      end
   end

   push_when_full_a : assert property (@(posedge clk) disable iff (rst)
      !(push && state == TWO))
      else $error("rd_skid_buf: push while buffer holds two words");

endmodule

// File: rtl/multi_fifo_rd_stage.sv
// Read stage for a multi-reader FIFO: one independent skid-buffered lane per
// reader, each turning the fall-through FIFO head into a registered stream.
module multi_fifo_rd_stage
   import multi_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int READER_NUM = DEF_READER_NUM,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input logic                    clk,
   input logic                    rst,
   multi_fifo_rd_stage_if.master  bus
);

   logic [READER_NUM-1:0]                 rden;
   logic [READER_NUM-1:0]                 valid;
   logic [READER_NUM-1:0][DATA_WIDTH-1:0] data;
   logic [READER_NUM-1:0][CNT_WIDTH-1:0]  beat_cnt;

   for (genvar i = 0; i < READER_NUM; i++) begin : g_lane
      rd_skid_buf #(
         .DATA_WIDTH (DATA_WIDTH),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .fifo_empty (bus.fifo_empty_i[i]),
         .fifo_rdata (bus.fifo_rdata_i[i]),
         .ready      (bus.ready_i[i]),
         .fifo_rden  (rden[i]),
         .valid      (valid[i]),
         .data       (data[i]),
         .beat_cnt   (beat_cnt[i])
      );
   end

   assign bus.fifo_rden_o = rden;
   assign bus.valid_o     = valid;
   assign bus.data_o      = data;
   assign bus.beat_cnt_o  = beat_cnt;

endmodule
